// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use detection, bubble insertion and operand forwarding.
// Build option: define FORWARD_EN to add the MEM/WB forward mux; otherwise RAW hazards stall.
`ifndef ALU_OP_LENGTH
`define ALU_OP_LENGTH 4
`endif

module id_ex_stage #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned ALU_OP_W = `ALU_OP_LENGTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_AW-1:0]   id_rs,
    input  logic [REG_AW-1:0]   id_rt,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic [DATA_W-1:0]   id_rs_data,
    input  logic [DATA_W-1:0]   id_rt_data,
    input  logic [DATA_W-1:0]   id_imm,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic                id_alu_src,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                id_mem_write,
    input  logic                flush,
    input  logic                mem_reg_write,
    input  logic [REG_AW-1:0]   mem_rd,
    input  logic [DATA_W-1:0]   mem_result,
    input  logic                wb_reg_write,
    input  logic [REG_AW-1:0]   wb_rd,
    input  logic [DATA_W-1:0]   wb_result,
    output logic                stall,
    output logic                ex_valid,
    output logic [DATA_W-1:0]   SrcA,
    output logic [DATA_W-1:0]   SrcB,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic [REG_AW-1:0]   ex_rd,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic [DATA_W-1:0]   ex_store_data
);

    logic                ex_valid_q, ex_valid_d;
    logic                ex_reg_write_q, ex_reg_write_d;
    logic                ex_mem_read_q, ex_mem_read_d;
    logic                ex_mem_write_q, ex_mem_write_d;
    logic                alu_src_q, alu_src_d;
    logic [REG_AW-1:0]   ex_rd_q, ex_rd_d;
    logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
    logic [DATA_W-1:0]   rs_data_q, rs_data_d;
    logic [DATA_W-1:0]   rt_data_q, rt_data_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
`ifdef FORWARD_EN
    logic [REG_AW-1:0]   ex_rs_q, ex_rs_d;
    logic [REG_AW-1:0]   ex_rt_q, ex_rt_d;
`endif

    logic                uses_rt;
    logic                ex_hit;
    logic                load_use;
    logic                raw_stall;
    logic                wb_hit_rs, wb_hit_rt;
    logic [DATA_W-1:0]   fwd_a, fwd_b;

    assign uses_rt  = !id_alu_src || id_mem_write;
    assign ex_hit   = (ex_rd_q != '0) &&
                      ((ex_rd_q == id_rs) || (uses_rt && (ex_rd_q == id_rt)));
    assign load_use = id_valid && ex_valid_q && ex_mem_read_q && ex_hit;

`ifdef FORWARD_EN
    assign raw_stall = 1'b0;
`else
    logic mem_hit;
    logic unused_mem_result;

    assign mem_hit   = (mem_rd != '0) &&
                       ((mem_rd == id_rs) || (uses_rt && (mem_rd == id_rt)));
    // Without forwarding, any producer still in EX or MEM must drain to WB first.
    assign raw_stall = id_valid &&
                       ((ex_valid_q && ex_reg_write_q && ex_hit) || (mem_reg_write && mem_hit));
    assign unused_mem_result = ^mem_result;
`endif

    // A flushed instruction is dead, so it must not hold up the front end.
    assign stall = !flush && (load_use || raw_stall);

    // WB writes the regfile this same cycle; latch its value instead of the stale read.
    assign wb_hit_rs = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs);
    assign wb_hit_rt = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rt);

    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_reg_write_d = ex_reg_write_q;
        ex_mem_read_d  = ex_mem_read_q;
        ex_mem_write_d = ex_mem_write_q;
        alu_src_d      = alu_src_q;
        ex_rd_d        = ex_rd_q;
        alu_op_d       = alu_op_q;
        rs_data_d      = rs_data_q;
        rt_data_d      = rt_data_q;
        imm_d          = imm_q;
`ifdef FORWARD_EN
        ex_rs_d        = ex_rs_q;
        ex_rt_d        = ex_rt_q;
`endif
        if (flush || stall) begin
            ex_valid_d     = 1'b0;
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
            ex_mem_write_d = 1'b0;
        end else begin
            ex_valid_d     = id_valid;
            ex_reg_write_d = id_reg_write;
            ex_mem_read_d  = id_mem_read;
            ex_mem_write_d = id_mem_write;
            alu_src_d      = id_alu_src;
            ex_rd_d        = id_rd;
            alu_op_d       = id_alu_op;
            rs_data_d      = wb_hit_rs ? wb_result : id_rs_data;
            rt_data_d      = wb_hit_rt ? wb_result : id_rt_data;
            imm_d          = id_imm;
`ifdef FORWARD_EN
            ex_rs_d        = id_rs;
            ex_rt_d        = id_rt;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q     <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
            alu_src_q      <= 1'b0;
            ex_rd_q        <= '0;
            alu_op_q       <= '0;
            rs_data_q      <= '0;
            rt_data_q      <= '0;
            imm_q          <= '0;
`ifdef FORWARD_EN
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
`endif
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_mem_write_q <= ex_mem_write_d;
            alu_src_q      <= alu_src_d;
            ex_rd_q        <= ex_rd_d;
            alu_op_q       <= alu_op_d;
            rs_data_q      <= rs_data_d;
            rt_data_q      <= rt_data_d;
            imm_q          <= imm_d;
`ifdef FORWARD_EN
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
`endif
        end
    end

`ifdef FORWARD_EN
    // MEM is the younger producer, so it wins over WB.
    always_comb begin
        fwd_a = rs_data_q;
        fwd_b = rt_data_q;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs_q)) begin
            fwd_a = mem_result;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs_q)) begin
            fwd_a = wb_result;
        end
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rt_q)) begin
            fwd_b = mem_result;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rt_q)) begin
            fwd_b = wb_result;
        end
    end
`else
    assign fwd_a = rs_data_q;
    assign fwd_b = rt_data_q;
`endif

    assign SrcA          = fwd_a;
    assign SrcB          = alu_src_q ? imm_q : fwd_b;
    assign ex_store_data = fwd_b;
    assign ex_valid      = ex_valid_q;
    assign ex_reg_write  = ex_reg_write_q;
    assign ex_mem_read   = ex_mem_read_q;
    assign ex_mem_write  = ex_mem_write_q;
    assign ex_rd         = ex_rd_q;
    assign ex_alu_op     = alu_op_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: instruction-record reference model, directed hazard programs
// run through a small MEM/WB pipeline model, then randomized traffic.
module tb_id_ex_stage;

    localparam int FWD =
`ifdef FORWARD_EN
        1;
`else
        0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_alu_src, id_reg_write, id_mem_read, id_mem_write, flush;
    logic [4:0]  id_rs, id_rt, id_rd, mem_rd, wb_rd, ex_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm, mem_result, wb_result;
    logic [3:0]  id_alu_op, ex_alu_op;
    logic        mem_reg_write, wb_reg_write;
    logic        stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [31:0] SrcA, SrcB, ex_store_data;

    id_ex_stage #(.DATA_W(32), .REG_AW(5), .ALU_OP_W(4)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .flush(flush),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .stall(stall), .ex_valid(ex_valid), .SrcA(SrcA), .SrcB(SrcB),
        .ex_alu_op(ex_alu_op), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_store_data(ex_store_data)
    );

    always #5 clk = ~clk;

    // Instruction sitting in EX, as the model sees it.
    typedef struct packed {
        logic        v, rw, mr, mw, src;
        logic [4:0]  rd, rs, rt;
        logic [3:0]  op;
        logic [31:0] a, b, imm;
    } rec_t;

    typedef struct packed {
        logic [4:0] rs, rt, rd;
        logic       src, rw, mr, mw, fl;
    } ins_t;

    rec_t        m;
    rec_t        memst, wbst;
    logic [31:0] mem_val, wb_val;
    ins_t        prog[$];
    int          checks = 0;
    int          errors = 0;
    int          stall_cnt = 0;
    logic        last_stall;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic reads(input logic [4:0] r);
        return (r != 0) && ((r == id_rs) || ((!id_alu_src || id_mem_write) && (r == id_rt)));
    endfunction

    function automatic logic exp_stall();
        logic s;
        if (flush || !id_valid) return 1'b0;
        s = m.v && m.mr && reads(m.rd);
`ifndef FORWARD_EN
        s = s || (m.v && m.rw && reads(m.rd)) || (mem_reg_write && reads(mem_rd));
`endif
        return s;
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] v);
`ifdef FORWARD_EN
        if (r != 0 && mem_reg_write && mem_rd == r) return mem_result;
        if (r != 0 && wb_reg_write && wb_rd == r) return wb_result;
`endif
        return (r == r) ? v : v;
    endfunction

    // Check outputs for the current cycle, then advance the model across one edge.
    task automatic step();
        rec_t nx;
        logic s;
        #1;
        s = exp_stall();
        check_eq("stall", {31'b0, stall}, {31'b0, s});
        check_eq("ex_valid", {31'b0, ex_valid}, {31'b0, m.v});
        check_eq("ex_reg_write", {31'b0, ex_reg_write}, {31'b0, m.rw});
        check_eq("ex_mem_read", {31'b0, ex_mem_read}, {31'b0, m.mr});
        check_eq("ex_mem_write", {31'b0, ex_mem_write}, {31'b0, m.mw});
        if (m.v || rst) begin
            check_eq("SrcA", SrcA, fwd(m.rs, m.a));
            check_eq("SrcB", SrcB, m.src ? m.imm : fwd(m.rt, m.b));
            check_eq("ex_store_data", ex_store_data, fwd(m.rt, m.b));
            check_eq("ex_rd", {27'b0, ex_rd}, {27'b0, m.rd});
            check_eq("ex_alu_op", {28'b0, ex_alu_op}, {28'b0, m.op});
        end
        nx = m;
        if (flush || s) begin
            nx.v = 0; nx.rw = 0; nx.mr = 0; nx.mw = 0;
        end else begin
            nx.v = id_valid; nx.rw = id_reg_write; nx.mr = id_mem_read;
            nx.mw = id_mem_write; nx.src = id_alu_src; nx.rd = id_rd;
            nx.rs = id_rs; nx.rt = id_rt; nx.op = id_alu_op; nx.imm = id_imm;
            nx.a = (wb_reg_write && wb_rd != 0 && wb_rd == id_rs) ? wb_result : id_rs_data;
            nx.b = (wb_reg_write && wb_rd != 0 && wb_rd == id_rt) ? wb_result : id_rt_data;
        end
        last_stall = s;
        if (s) stall_cnt++;
        @(posedge clk);
        if (rst) m = '0;
        else m = nx;
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic src, input logic rw,
                          input logic mr, input logic mw);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_alu_src = src;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
        id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
        id_alu_op = 4'($urandom);
    endtask

    task automatic set_mw(input logic mw_, input logic [4:0] mrd, input logic [31:0] mv,
                          input logic ww, input logic [4:0] wrd, input logic [31:0] wv);
        mem_reg_write = mw_; mem_rd = mrd; mem_result = mv;
        wb_reg_write = ww; wb_rd = wrd; wb_result = wv;
    endtask

    // Feed the program queue through ID; MEM/WB inputs come from what left EX earlier.
    task automatic run_prog(input int cycles);
        rec_t prev;
        memst = '0; wbst = '0; stall_cnt = 0;
        for (int c = 0; c < cycles; c++) begin
            set_mw(memst.v && memst.rw, memst.rd, mem_val, wbst.v && wbst.rw, wbst.rd, wb_val);
            if (prog.size() > 0) begin
                set_id(1'b1, prog[0].rs, prog[0].rt, prog[0].rd, prog[0].src, prog[0].rw,
                       prog[0].mr, prog[0].mw);
                flush = prog[0].fl;
            end else begin
                set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
                flush = 1'b0;
            end
            prev = m;
            step();
            if (prog.size() > 0 && !last_stall) void'(prog.pop_front());
            wbst = memst; wb_val = $urandom;
            memst = prev; mem_val = $urandom;
        end
        check_eq("prog_drained", prog.size(), 0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_mw(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        m = '0; mem_val = 0; wb_val = 0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;

        // add r3,r1,r2 ; sub r4,r3,r1
        prog.push_back('{rs: 1, rt: 2, rd: 3, src: 0, rw: 1, mr: 0, mw: 0, fl: 0});
        prog.push_back('{rs: 3, rt: 1, rd: 4, src: 0, rw: 1, mr: 0, mw: 0, fl: 0});
        run_prog(7);
        check_eq("s2_stall_cycles", stall_cnt, (FWD != 0) ? 0 : 2);

        // lw r5 ; addu r6,r5,r0
        prog.push_back('{rs: 1, rt: 0, rd: 5, src: 1, rw: 1, mr: 1, mw: 0, fl: 0});
        prog.push_back('{rs: 5, rt: 0, rd: 6, src: 0, rw: 1, mr: 0, mw: 0, fl: 0});
        run_prog(7);
        check_eq("s3_stall_cycles", stall_cnt, (FWD != 0) ? 1 : 2);

        // lw r5 ; addu r6,r5 killed by flush ; or r7,r1,r2 enters behind the bubble
        prog.push_back('{rs: 1, rt: 0, rd: 5, src: 1, rw: 1, mr: 1, mw: 0, fl: 0});
        prog.push_back('{rs: 5, rt: 0, rd: 6, src: 0, rw: 1, mr: 0, mw: 0, fl: 1});
        prog.push_back('{rs: 1, rt: 2, rd: 7, src: 0, rw: 1, mr: 0, mw: 0, fl: 0});
        run_prog(7);
        check_eq("s5_stall_cycles", stall_cnt, 0);

        // producer two instructions ahead of its consumer
        prog.push_back('{rs: 1, rt: 2, rd: 3, src: 0, rw: 1, mr: 0, mw: 0, fl: 0});
        prog.push_back('{rs: 1, rt: 1, rd: 9, src: 0, rw: 1, mr: 0, mw: 0, fl: 0});
        prog.push_back('{rs: 3, rt: 2, rd: 10, src: 0, rw: 1, mr: 0, mw: 0, fl: 0});
        run_prog(8);
        check_eq("s6_stall_cycles", stall_cnt, (FWD != 0) ? 0 : 1);

        // MEM and WB both write r7; MEM value must win when forwarding
        set_mw(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
        set_id(1'b1, 5'd7, 5'd7, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef FORWARD_EN
        #1 check_eq("s4_mem_over_wb", SrcA, 32'h11);
`endif
        step();
        // r0 is never a forward source
        set_mw(1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22);
        set_id(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        id_rs_data = 32'h44;
        step();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 check_eq("s4_r0_latched", SrcA, 32'h44);
        step();

        // reset mid-run while EX holds a real instruction
        set_mw(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        id_rs_data = 32'hdead_beef;
        step();
        check_eq("s1_pre_valid", {31'b0, ex_valid}, 32'd1);
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        m = '0;
        #1;
        check_eq("s1_valid", {31'b0, ex_valid}, 32'd0);
        check_eq("s1_srca", SrcA, 32'd0);
        check_eq("s1_srcb", SrcB, 32'd0);
        check_eq("s1_stall", {31'b0, stall}, 32'd0);
        step();
        rst = 1'b0;

        // randomized traffic on a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            set_id($urandom_range(0, 9) < 8, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
            flush = $urandom_range(0, 9) == 0;
            set_mw(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
                   1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
